// File: rtl/block_data_memory_pkg.sv
// Shared definitions for the block data memory: default geometry, latency and FSM encoding.
// The cache imports the same defaults so its tag/index split stays consistent.
package block_data_memory_pkg;

    localparam int unsigned ADDR_W_DEF  = 6;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned LATENCY_DEF = 5;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

endpackage

// File: rtl/block_data_memory_if.sv
// Cache-to-memory block request bus: request/data from the cache, data/stall back from memory.
interface block_data_memory_if
    import block_data_memory_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );

endinterface

// File: rtl/block_data_memory_mem_array.sv
// Block register file: synchronous write, registered read, asynchronous active-low clear of
// every word and of the read register.
module block_data_memory_mem_array
    import block_data_memory_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[ADDR_W'(i)] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/block_data_memory.sv
// Block-addressed backing memory behind the data cache: latches one request in IDLE, waits
// LATENCY cycles in ACCESS, commits the read or write, then releases the stall for one ACK cycle.
module block_data_memory
    import block_data_memory_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned LATENCY = LATENCY_DEF
) (
    input  logic                clock,
    input  logic                reset,
    block_data_memory_if.slave  bus
);

    state_e             state_q;
    logic               op_wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               req_c;
    logic               commit_c;
    logic               busy_c;
    logic [DATA_W-1:0]  rdata;

    assign req_c    = bus.read | bus.write;
    assign commit_c = (state_q == ST_ACCESS) && (cnt_q == '0);

    // Request latches, latency counter and state; inputs are only sampled at the IDLE edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_c) begin
                        op_wr_q <= bus.write;
                        addr_q  <= bus.address;
                        data_q  <= bus.writedata;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational in IDLE so the cache holds in its request cycle.
    always_comb begin
        busy_c = 1'b0;
        case (state_q)
            ST_IDLE:   busy_c = req_c;
            ST_ACCESS: busy_c = 1'b1;
            default:   busy_c = 1'b0;
        endcase
    end

    assign bus.busywait = reset & busy_c;

    block_data_memory_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk_i   (clock),
        .rst_ni  (reset),
        .we_i    (commit_c & op_wr_q),
        .re_i    (commit_c & ~op_wr_q),
        .addr_i  (addr_q),
        .wdata_i (data_q),
        .rdata_o (rdata)
    );

    assign bus.readdata = rdata;

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: the driver queues the expected ACK data per request and
// a forked monitor checks stall length and readdata whenever busywait falls.
module tb_block_data_memory;

    localparam int unsigned LAT = 5;

    typedef struct {
        logic [31:0] data;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];

    block_data_memory_if bus ();

    block_data_memory #(
        .ADDR_W  (6),
        .DATA_W  (32),
        .LATENCY (LAT)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Counts stall cycles at each negedge and scores every ACK against the queue head.
    task automatic monitor();
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else if (bus.busywait) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ack: got ack with empty queue expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_busy_len"}, 32'(busy_cnt), 32'(LAT + 1));
                    chk({e.name, "_rdata"}, bus.readdata, e.data);
                end
                busy_cnt = 0;
            end
        end
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [5:0] a,
                          input logic [31:0] d, input logic [31:0] exp,
                          input string nm, input bit glitch);
        exp_t e;
        bit   done;
        @(posedge clk);
        #1;
        bus.read      = rd;
        bus.write     = wr;
        bus.address   = a;
        bus.writedata = d;
        e.data = exp;
        e.name = nm;
        exp_q.push_back(e);
        if (glitch) begin
            @(posedge clk);
            #1;
            bus.address   = 6'd3;
            bus.writedata = 32'hFFFF_FFFF;
        end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!bus.busywait) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no ack within 40 cycles expected ack", nm);
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.read      = 1'b1;
        bus.write     = 1'b0;
        bus.address   = 6'd12;
        bus.writedata = '0;
        fork
            monitor();
        join_none

        // Reset held with a request present: no stall, cleared read data.
        repeat (3) @(negedge clk);
        chk("reset_busywait", 32'(bus.busywait), 32'd0);
        chk("reset_readdata", bus.readdata, 32'd0);
        bus.read = 1'b0;
        #2 rst_n = 1'b1;

        do_req(1'b1, 1'b0, 6'd12, 32'h0,         32'h0,         "rd12_after_reset", 1'b0);
        do_req(1'b0, 1'b1, 6'd5,  32'hDEADBEEF,  32'h0,         "wr5",              1'b0);
        do_req(1'b1, 1'b0, 6'd5,  32'h0,         32'hDEADBEEF,  "rd5",              1'b0);
        do_req(1'b1, 1'b1, 6'd63, 32'h12345678,  32'hDEADBEEF,  "rdwr63",           1'b0);
        do_req(1'b1, 1'b0, 6'd63, 32'h0,         32'h12345678,  "rd63",             1'b0);

        // Write to block 9 aborted by a reset pulse in ACCESS cycle 3.
        @(posedge clk);
        #1;
        bus.read      = 1'b0;
        bus.write     = 1'b1;
        bus.address   = 6'd9;
        bus.writedata = 32'hA5A5A5A5;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busywait", 32'(bus.busywait), 32'd0);
        chk("midreset_readdata", bus.readdata, 32'd0);
        bus.write = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        do_req(1'b1, 1'b0, 6'd9,  32'h0,         32'h0,         "rd9_after_abort",  1'b0);
        do_req(1'b1, 1'b0, 6'd63, 32'h0,         32'h0,         "rd63_cleared",     1'b0);
        do_req(1'b0, 1'b1, 6'd2,  32'h0BADF00D,  32'h0,         "wr2_glitch",       1'b1);
        do_req(1'b1, 1'b0, 6'd2,  32'h0,         32'h0BADF00D,  "rd2",              1'b0);
        do_req(1'b1, 1'b0, 6'd3,  32'h0,         32'h0,         "rd3",              1'b0);
        do_req(1'b0, 1'b1, 6'd0,  32'h11111111,  32'h0,         "wr0",              1'b0);
        do_req(1'b0, 1'b1, 6'd1,  32'h22222222,  32'h0,         "wr1",              1'b0);
        do_req(1'b1, 1'b0, 6'd0,  32'h0,         32'h11111111,  "b2b_rd0",          1'b0);
        do_req(1'b1, 1'b0, 6'd1,  32'h0,         32'h22222222,  "b2b_rd1",          1'b0);
        do_req(1'b1, 1'b0, 6'd2,  32'h0,         32'h0BADF00D,  "b2b_rd2",          1'b0);
        go_idle();

        // Read data holds in IDLE, and every queued access was acknowledged exactly once.
        repeat (4) @(negedge clk);
        chk("hold_readdata", bus.readdata, 32'h0BADF00D);
        chk("idle_busywait", 32'(bus.busywait), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
